// File: rtl/ddr_ctr_rd_resp_pkg.sv
// ddr_ctr_rd_resp_pkg: shared resp codes, FSM encoding and beat-record sizing
package ddr_ctr_rd_resp_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   // A buffered beat carries {resp[1:0], last, data}
   localparam int BEAT_EXTRA = 3;

   function automatic int beat_w(input int data_w);
      return data_w + BEAT_EXTRA;
   endfunction

endpackage

// File: rtl/ddr_ctr_rd_resp_fifo.sv
// rd_resp_fifo: 2-entry synchronous FIFO holding R-channel beat records
module rd_resp_fifo #(
   parameter int W = 35
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wp;
   logic         rp;

   // Storage and pointers; entries clear on reset so the head reads zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rp];
   assign full  = count == 2'd2;
   assign empty = count == 2'd0;

endmodule

// File: rtl/ddr_ctr_rd_resp.sv
// ddr_ctr_rd_resp: AXI4-style read responder with init delay and 1-cycle memory port
module ddr_ctr_rd_resp
   import ddr_ctr_rd_resp_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_AW      = 10,
   parameter int INIT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ddr_ready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BL = $clog2(DATA_W / 8);
   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int BW = beat_w(DATA_W);

   state_t            state, state_nx;
   logic [IW-1:0]     init_cnt;
   logic [ADDR_W-1:0] word;
   logic              err;
   logic [8:0]        left;
   logic              infl;
   logic              infl_last;
   logic              ar_hs;
   logic              issue;
   logic [2:0]        occ;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [1:0]        count;
   logic [BW-1:0]     din;
   logic [BW-1:0]     dout;

   // Post-reset init delay; saturates once ddr_ready is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) init_cnt <= '0;
      else if (init_cnt != IW'(INIT_CYCLES)) init_cnt <= init_cnt + 1'b1;
   end

   assign ddr_ready = init_cnt == IW'(INIT_CYCLES);
   assign word      = araddr >> BL;
   assign ar_hs     = arvalid & arready;
   assign pop       = rvalid & rready;

   // Credit counts a beat leaving this cycle so a streaming burst sustains one beat per cycle
   assign occ   = {1'b0, count} + {2'b0, infl} - {2'b0, pop};
   assign issue = state == ST_BURST && left != 9'd0 && occ < 3'd2;
   assign mem_en = issue & ~err;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_INIT;
      else     state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      if (state == ST_INIT && ddr_ready) state_nx = ST_IDLE;
      else if (state == ST_IDLE && ar_hs) state_nx = ST_BURST;
      else if (state == ST_BURST && pop && rlast) state_nx = ST_IDLE;
   end

   // FSM outputs
   always_comb begin
      arready = state == ST_IDLE;
   end

   // Burst context and issue tracking; error beats share the read pipeline timing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         err       <= 1'b0;
         left      <= 9'd0;
         infl      <= 1'b0;
         infl_last <= 1'b0;
      end else begin
         infl      <= issue;
         infl_last <= issue && left == 9'd1;
         if (ar_hs) begin
            mem_addr <= araddr[BL +: MEM_AW];
            err      <= word >= ADDR_W'(2 ** MEM_AW);
            left     <= {1'b0, arlen} + 9'd1;
         end else if (issue) begin
            mem_addr <= mem_addr + 1'b1;
            left     <= left - 9'd1;
         end
      end
   end

   assign push = infl & ~full;
   assign din  = {err ? RESP_SLVERR : RESP_OKAY, infl_last, err ? {DATA_W{1'b0}} : mem_rdata};

   rd_resp_fifo #(.W(BW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign rvalid = ~empty;
   assign rdata  = empty ? {DATA_W{1'b0}} : dout[DATA_W-1:0];
   assign rlast  = ~empty & dout[DATA_W];
   assign rresp  = empty ? RESP_OKAY : dout[DATA_W+2:DATA_W+1];

endmodule
